flow_fifo: RTL
==============

# flow_fifo

Synchronous valid/ready FIFO stage that decouples the 16-bit wide link between `flow_8to16` (producer) and `flow_16to8` (consumer). It absorbs backpressure bursts so the width converters do not stall each other cycle-by-cycle. The block preserves word order and never drops or duplicates a word. It holds its contents while `cfg_en` is low.

## Interface
- `DATAW`, 16, width of each data word.
- `DEPTH`, 4, number of storage entries; must be a power of two and at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active low. One clock; reset is asynchronous and active-low.
- `cfg_en`  in  1  enable, active high.
- `src_val`  in  1  upstream valid, active high.
- `src_rdy`  out  1  upstream ready, active high.
- `src_data`  in  DATAW  upstream data; steady while `src_val` is high.
- `dst_val`  out  1  downstream valid, active high.
- `dst_rdy`  in  1  downstream ready, active high.
- `dst_data`  out  DATAW  downstream data; steady while `dst_val` is high.
- `level`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer with write pointer `wptr` and read pointer `rptr`, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus an occupancy counter `cnt` of width $clog2(DEPTH+1).
- Push: occurs when `src_val && src_rdy`. `mem[wptr] <= src_data` and `wptr` increments.
- Pop: occurs when `dst_val && dst_rdy`. `rptr` increments.
- `cnt` update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- `src_rdy = cfg_en && (cnt != DEPTH)`.
  - There is no combinational path from `dst_rdy` to `src_rdy`.
  - When full, the block accepts nothing in that cycle, even if a pop happens in the same cycle.
- `dst_val = cfg_en && (cnt != 0)`; `dst_data = mem[rptr]`.
- `level = cnt`.
- Simultaneous push and pop at `cnt` between 1 and DEPTH-1: both pointers advance and `cnt` is unchanged.
- Push and pop never target the same entry in the same cycle, because a pop requires `cnt >= 1`.
- `cfg_en` low: `src_rdy` and `dst_val` are 0. Pointers, `cnt` and memory are held, not flushed. Operation resumes with the same contents when `cfg_en` returns high.
- Reset, at any time including mid-burst: `wptr`, `rptr` and `cnt` are cleared to 0, so all stored words are discarded. Memory contents are not reset.
- Reset values of outputs: `src_rdy` = `cfg_en` (the FIFO is empty), `dst_val` = 0, `level` = 0. `dst_data` is don't-care while `dst_val` is 0.

## Timing
- Latency without bypass: a word pushed in cycle N is presented with `dst_val` = 1 in cycle N+1 at the earliest.
- Throughput: one word per cycle when not full and not empty.
- Once `dst_val` is high it stays high with `dst_data` stable until the pop.
- All outputs are functions of registered state and `cfg_en` only, except in bypass mode (see Configuration).

## Configuration
- Macro: `FLOW_FIFO_BYPASS_EN`.
- Defined: when `cnt == 0` and `cfg_en` is high:
  - `dst_val = src_val` and `dst_data = src_data`, combinationally.
  - If `dst_rdy` is high, the word passes straight through with zero latency. It is not written and the pointers and `cnt` do not change.
  - If `dst_rdy` is low, the word is pushed normally.
  - `src_rdy` is unchanged (1 when empty).
- Not defined: strict registered behaviour as described in Operation and Timing.

## Structure
- Shared package `flow_pkg` holds:
  - the function `flow_clog2`;
  - the default data width constant `FLOW_DATAW = 16`;
  - the default depth constant `FLOW_FIFO_DEPTH = 4`.
- One sub-module, `flow_fifo_mem`: DEPTH x DATAW register array with one write port and one asynchronous read port, and no reset.
- Pointer, counter and handshake control stay in `flow_fifo`.

## Test plan
- Reset with `src_val` = 1 and `src_data` = 16'hAAAA held during reset -> `dst_val` = 0, `level` = 0 and `src_rdy` = 1 throughout reset; no word appears afterwards unless pushed after reset release.
- Fill with `dst_rdy` = 0, pushing 16'h0001..16'h0004 -> `src_rdy` drops to 0 after the 4th push and `level` = 4. A 5th value 16'h0005 held on `src_val` is not accepted. Then `dst_rdy` = 1 -> output order is 0001, 0002, 0003, 0004, 0005.
- Continuous streaming of 64 incrementing words with `dst_rdy` = 1 -> one word out per cycle after a 1-cycle latency (0 cycles with `FLOW_FIFO_BYPASS_EN`); `level` stays at 1 or below.
- Random `src_val` and `dst_rdy` at 50% each over 1000 words, with `vld_rdy_checker` on both sides -> in-order, lossless delivery; `dst_data` stable while `dst_val` is high and not ready; pointers wrap correctly.
- At `level` = 2, drive `cfg_en` = 0 for 5 cycles with `src_val` and `dst_rdy` both high -> no transfers and `level` stays at 2; after `cfg_en` = 1, both words drain in their original order.
- Assert `rst_n` low for 1 cycle at `level` = 3 -> `level` = 0 and `dst_val` = 0 immediately (asynchronously); the old words are never output.

Source files
------------

// File: rtl/flow_pkg.sv
// Shared definitions for the flow_* width-converter link: default widths and a
// constant-safe ceil(log2) used to size pointers and counters.
package flow_pkg;

    localparam int FLOW_DATAW      = 16;
    localparam int FLOW_FIFO_DEPTH = 4;

    // Handshake activity in one cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        FLOW_OP_IDLE = 2'b00,
        FLOW_OP_POP  = 2'b01,
        FLOW_OP_PUSH = 2'b10,
        FLOW_OP_BOTH = 2'b11
    } flow_op_e;

    function automatic int flow_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/flow_fifo_mem.sv
// DEPTH x DATAW register array for flow_fifo: one synchronous write port and
// one asynchronous read port.
module flow_fifo_mem
    import flow_pkg::*;
#(
    parameter  int DATAW = FLOW_DATAW,
    parameter  int DEPTH = FLOW_FIFO_DEPTH,
    localparam int AW    = flow_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [DATAW-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [DATAW-1:0] o_rd_data
);

    logic [DATAW-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers and
    // counter in the parent, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/flow_fifo.sv
// Valid/ready FIFO between flow_8to16 and flow_16to8. Define FLOW_FIFO_BYPASS_EN
// for zero-latency pass-through when empty; default is fully registered output.
module flow_fifo
    import flow_pkg::*;
#(
    parameter  int DATAW = FLOW_DATAW,
    parameter  int DEPTH = FLOW_FIFO_DEPTH,
    localparam int AW    = flow_clog2(DEPTH),
    localparam int CW    = flow_clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             src_val,
    output logic             src_rdy,
    input  logic [DATAW-1:0] src_data,
    output logic             dst_val,
    input  logic             dst_rdy,
    output logic [DATAW-1:0] dst_data,
    output logic [CW-1:0]    level
);

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    w_wptr_nxt;
    logic [AW-1:0]    w_rptr_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [DATAW-1:0] w_rd_data;
    flow_op_e         w_op;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);

    // Ready depends only on state, so a full FIFO refuses even when popping.
    assign src_rdy = cfg_en && !w_full;
    assign level   = r_cnt;

`ifdef FLOW_FIFO_BYPASS_EN
    logic w_bypass;

    assign w_bypass = cfg_en && w_empty;
    assign dst_val  = w_bypass ? src_val  : (cfg_en && !w_empty);
    assign dst_data = w_bypass ? src_data : w_rd_data;
    // A word consumed straight through never touches storage.
    assign w_push   = src_val && src_rdy && !(w_bypass && dst_rdy);
    assign w_pop    = cfg_en && !w_empty && dst_rdy;
`else
    assign dst_val  = cfg_en && !w_empty;
    assign dst_data = w_rd_data;
    assign w_push   = src_val && src_rdy;
    assign w_pop    = dst_val && dst_rdy;
`endif

    assign w_op = flow_op_e'({w_push, w_pop});

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_cnt_nxt  = r_cnt;
        if (w_push) begin
            w_wptr_nxt = r_wptr + AW'(1);
        end
        if (w_pop) begin
            w_rptr_nxt = r_rptr + AW'(1);
        end
        case (w_op)
            FLOW_OP_PUSH: w_cnt_nxt = r_cnt + CW'(1);
            FLOW_OP_POP:  w_cnt_nxt = r_cnt - CW'(1);
            default:      w_cnt_nxt = r_cnt;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    flow_fifo_mem #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wptr),
        .i_wr_data (src_data),
        .i_rd_addr (r_rptr),
        .o_rd_data (w_rd_data)
    );

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_cnt <= CW'(DEPTH));

    a_ptr_cnt_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (r_wptr - r_rptr) == r_cnt[AW-1:0]);

endmodule
